ddr_port_arbiter: RTL and testbench
===================================

// Module: ddr_port_arbiter
// PURPOSE
//  Shares the single-port DDR3 user interface (wr_en/rd_en/busy/rd_data_valid) between NUM_PORTS
//  requesters (Ethernet RX writer, frame reader, debug dump). Round-robin grant, one command
//  per cycle, in-order read-return routing via a tag FIFO. Sits between the requesters and the DDR controller, in the ui_clk domain.
// PARAMETERS
//  NUM_PORTS    3    requester count, 2..8
//  ADDR_WIDTH   25   DDR controller address width
//  DATA_WIDTH   256  DDR controller data width
//  RD_OUTST     16   max reads in flight (tag FIFO depth, power of 2)
// PORTS
//  clk            in   1             ui_clk of DDR controller
//  rst_n          in   1             asynchronous, active-low reset
//  p_req          in   NUM_PORTS     per-port command request (level, held until p_gnt)
//  p_we           in   NUM_PORTS     1=write, 0=read
//  p_addr         in   NUM_PORTS*AW  per-port address, port i at [i*AW +: AW]
//  p_wdata        in   NUM_PORTS*DW  per-port write data
//  p_gnt          out  NUM_PORTS     one-hot pulse: command of that port accepted this cycle
//  p_rvalid       out  NUM_PORTS     one-hot pulse: p_rdata belongs to that port
//  p_rdata        out  DW            read data (shared bus)
//  ddr_wr_en/ddr_wr_addr/ddr_wr_data  out  1/AW/DW  to controller write side
//  ddr_rd_en/ddr_rd_addr              out  1/AW     to controller read side
//  ddr_wr_busy/ddr_rd_busy            in   1        controller busy flags
//  ddr_rd_data/ddr_rd_data_valid      in   DW/1     controller read return
//  rd_outstanding out  $clog2(RD_OUTST)+1  reads in flight
//  err_orphan_rd  out  1             sticky: read return with no tag pending
// BEHAVIOUR
//  - Reset: all outputs 0; rr_ptr=NUM_PORTS-1 (port 0 highest priority first); tag FIFO empty.
//  - Eligible(i) = p_req[i] & (p_we[i] ? !ddr_wr_busy : (!ddr_rd_busy & !tag_full)).
//  - Winner: first eligible port scanning rr_ptr+1, rr_ptr+2 .. wrapping modulo NUM_PORTS.
//  - Issue is combinational, same cycle: ddr_wr_en or ddr_rd_en=1 with winner's addr/data, p_gnt[winner]=1;
//    rr_ptr<=winner on next edge. No eligible port -> no en, no gnt, rr_ptr unchanged.
//  - At most one of ddr_wr_en/ddr_rd_en per cycle; address/data outputs 0 when not enabled.
//  - Read issue pushes winner index into tag FIFO; ddr_rd_data_valid pops head tag t and drives
//    p_rvalid[t]=1, p_rdata=ddr_rd_data same cycle (combinational); p_rdata=0 otherwise.
//  - Push and pop same cycle: both happen, occupancy unchanged; allowed when full (pop frees slot
//    only next cycle: tag_full blocks issue in that cycle).
//  - ddr_rd_data_valid with FIFO empty: no p_rvalid, err_orphan_rd<=1 until reset.
//  - Requester deasserting p_req without gnt: legal, request dropped; a port must not change
//    p_we/p_addr/p_wdata while p_req=1 and not granted.
//  - rst_n asserted mid-operation: in-flight read tags discarded; returns after reset flag err_orphan_rd.
// CONFIGURATION
//  DDR_ARB_PERF_CNT_EN defined: adds output perf_gnt_cnt [NUM_PORTS*32] (per-port grant count,
//    wraps at 2^32) and perf_stall_cnt [32] (cycles with any p_req and no grant); both reset to 0.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  ddr_arb_pkg: TAG_W function ($clog2(NUM_PORTS)), MAX_PORTS=8, rr_next() helper function.
//  Sub-module ddr_arb_tag_fifo: synchronous FIFO, width TAG_W, depth RD_OUTST, full/empty/count.
//  Top holds rr pointer, eligibility/grant logic, muxes, error flag, optional perf counters.
// TESTING
//  1 Reset: rst_n=0 mid-traffic -> all outputs 0, rd_outstanding=0, next grant goes to port 0.
//  2 Ports 0,1,2 hold write req, busy=0 -> gnt order 0,1,2,0,1,2; ddr_wr_addr tracks port.
//  3 Port0 read req + port1 write req, ddr_rd_busy=1 -> port1 granted; release busy -> port0 next.
//  4 Issue 16 reads (RD_OUTST=16), no returns -> 17th read blocked, writes still granted.
//  5 Reads from ports 2,0,1 then 3 valid pulses -> p_rvalid 2,0,1 with matching data.
//  6 ddr_rd_data_valid with empty FIFO -> err_orphan_rd=1 held; with DDR_ARB_PERF_CNT_EN, counts match grants.

Source files
------------

// File: rtl/ddr_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ddr_arb_pkg : shared sizing constants and round-robin helper               |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package ddr_arb_pkg;

   localparam int MAX_PORTS = 8;
   localparam int PTR_W     = $clog2(MAX_PORTS);

   function automatic int tag_w(input int num_ports);
      return (num_ports > 1) ? $clog2(num_ports) : 1;
   endfunction

   function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] ptr,
                                                input int num_ports);
      if (int'(ptr) >= num_ports - 1)
         return '0;
      return ptr + PTR_W'(1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ddr_arb_tag_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ddr_arb_tag_fifo : synchronous FIFO of port tags for in-order read return  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ddr_arb_tag_fifo #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

   // A pop in the same cycle lets a push land even when full.
   always_comb begin
      do_pop   = pop & ~empty;
      do_push  = push & (~full | do_pop);
      wr_ptr_d = wr_ptr_q + IDX_W'(do_push);
      rd_ptr_d = rd_ptr_q + IDX_W'(do_pop);
      count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem_q[wr_ptr_q] <= push_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/ddr_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ddr_port_arbiter : round-robin share of the DDR user port, tagged returns  |
// | Optional DDR_ARB_PERF_CNT_EN adds grant/stall counters.   Rev 1.0          |
// +----------------------------------------------------------------------------+
module ddr_port_arbiter
   import ddr_arb_pkg::*;
#(
   parameter int NUM_PORTS  = 3,
   parameter int ADDR_WIDTH = 25,
   parameter int DATA_WIDTH = 256,
   parameter int RD_OUTST   = 16
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_PORTS-1:0]            p_req,
   input  logic [NUM_PORTS-1:0]            p_we,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0] p_addr,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] p_wdata,
   output logic [NUM_PORTS-1:0]            p_gnt,
   output logic [NUM_PORTS-1:0]            p_rvalid,
   output logic [DATA_WIDTH-1:0]           p_rdata,
   output logic                            ddr_wr_en,
   output logic [ADDR_WIDTH-1:0]           ddr_wr_addr,
   output logic [DATA_WIDTH-1:0]           ddr_wr_data,
   output logic                            ddr_rd_en,
   output logic [ADDR_WIDTH-1:0]           ddr_rd_addr,
   input  logic                            ddr_wr_busy,
   input  logic                            ddr_rd_busy,
   input  logic [DATA_WIDTH-1:0]           ddr_rd_data,
   input  logic                            ddr_rd_data_valid,
   output logic [$clog2(RD_OUTST):0]       rd_outstanding,
   output logic                            err_orphan_rd
`ifdef DDR_ARB_PERF_CNT_EN
   ,
   output logic [NUM_PORTS*32-1:0]         perf_gnt_cnt,
   output logic [31:0]                     perf_stall_cnt
`endif
);

   localparam int TAG_W = tag_w(NUM_PORTS);

   logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]      cand, win;
   logic                  found;
   logic [NUM_PORTS-1:0]  elig;
   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic                  tag_full, tag_empty, tag_pop;
   logic [TAG_W-1:0]      tag_head;
   logic                  err_orphan_q, err_orphan_d;

   always_comb begin
      elig = p_req & ((p_we & {NUM_PORTS{~ddr_wr_busy}}) |
                      (~p_we & {NUM_PORTS{~ddr_rd_busy & ~tag_full}}));
      found = 1'b0;
      win   = '0;
      cand  = rr_ptr_q;
      // Walk rr_ptr+1, rr_ptr+2, ... and keep the first eligible port.
      for (int k = 0; k < NUM_PORTS; k++) begin
         cand = rr_next(cand, NUM_PORTS);
         for (int j = 0; j < NUM_PORTS; j++) begin
            if (!found && elig[j] && cand == PTR_W'(j)) begin
               found = 1'b1;
               win   = cand;
            end
         end
      end
   end

   always_comb begin
      p_gnt     = '0;
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int j = 0; j < NUM_PORTS; j++) begin
         if (found && win == PTR_W'(j)) begin
            p_gnt[j]  = 1'b1;
            sel_we    = p_we[j];
            sel_addr  = p_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata = p_wdata[j*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      ddr_wr_en   = found & sel_we;
      ddr_rd_en   = found & ~sel_we;
      ddr_wr_addr = ddr_wr_en ? sel_addr  : '0;
      ddr_wr_data = ddr_wr_en ? sel_wdata : '0;
      ddr_rd_addr = ddr_rd_en ? sel_addr  : '0;
      rr_ptr_d    = found ? win : rr_ptr_q;
   end

   always_comb begin
      tag_pop      = ddr_rd_data_valid & ~tag_empty;
      p_rvalid     = '0;
      for (int j = 0; j < NUM_PORTS; j++)
         p_rvalid[j] = tag_pop && (tag_head == TAG_W'(j));
      p_rdata      = tag_pop ? ddr_rd_data : '0;
      err_orphan_d = err_orphan_q | (ddr_rd_data_valid & tag_empty);
   end

   assign err_orphan_rd = err_orphan_q;

   ddr_arb_tag_fifo #(
      .WIDTH (TAG_W),
      .DEPTH (RD_OUTST)
   ) u_tag_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (ddr_rd_en),
      .push_data (win[TAG_W-1:0]),
      .pop       (tag_pop),
      .head      (tag_head),
      .full      (tag_full),
      .empty     (tag_empty),
      .count     (rd_outstanding)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q     <= PTR_W'(NUM_PORTS - 1);
         err_orphan_q <= 1'b0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         err_orphan_q <= err_orphan_d;
      end
   end

`ifdef DDR_ARB_PERF_CNT_EN
   logic [31:0] gnt_cnt_q [NUM_PORTS];
   logic [31:0] gnt_cnt_d [NUM_PORTS];
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      for (int j = 0; j < NUM_PORTS; j++)
         gnt_cnt_d[j] = gnt_cnt_q[j] + {31'b0, p_gnt[j]};
      stall_cnt_d = stall_cnt_q + {31'b0, (|p_req) & ~found};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < NUM_PORTS; j++)
            gnt_cnt_q[j] <= '0;
         stall_cnt_q <= '0;
      end else begin
         for (int j = 0; j < NUM_PORTS; j++)
            gnt_cnt_q[j] <= gnt_cnt_d[j];
         stall_cnt_q <= stall_cnt_d;
      end
   end

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_perf_out
      assign perf_gnt_cnt[g*32 +: 32] = gnt_cnt_q[g];
   end
   assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ddr_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ddr_port_arbiter : directed scenarios plus randomized traffic vs model  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_ddr_port_arbiter;

   localparam int N  = 3;
   localparam int AW = 25;
   localparam int DW = 256;
   localparam int RO = 16;
   localparam int CW = $clog2(RO) + 1;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    p_req, p_we, p_gnt, p_rvalid;
   logic [N*AW-1:0] p_addr;
   logic [N*DW-1:0] p_wdata;
   logic [DW-1:0]   p_rdata, ddr_wr_data, ddr_rd_data;
   logic            ddr_wr_en, ddr_rd_en, ddr_wr_busy, ddr_rd_busy, ddr_rd_data_valid;
   logic [AW-1:0]   ddr_wr_addr, ddr_rd_addr;
   logic [CW-1:0]   rd_outstanding;
   logic            err_orphan_rd;
`ifdef DDR_ARB_PERF_CNT_EN
   logic [N*32-1:0] perf_gnt_cnt;
   logic [31:0]     perf_stall_cnt;
`endif

   ddr_port_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_OUTST(RO)) dut (
      .clk(clk), .rst_n(rst_n), .p_req(p_req), .p_we(p_we), .p_addr(p_addr),
      .p_wdata(p_wdata), .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
      .ddr_wr_en(ddr_wr_en), .ddr_wr_addr(ddr_wr_addr), .ddr_wr_data(ddr_wr_data),
      .ddr_rd_en(ddr_rd_en), .ddr_rd_addr(ddr_rd_addr), .ddr_wr_busy(ddr_wr_busy),
      .ddr_rd_busy(ddr_rd_busy), .ddr_rd_data(ddr_rd_data),
      .ddr_rd_data_valid(ddr_rd_data_valid), .rd_outstanding(rd_outstanding),
      .err_orphan_rd(err_orphan_rd)
`ifdef DDR_ARB_PERF_CNT_EN
      , .perf_gnt_cnt(perf_gnt_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state: last winner, queue of port tags for reads in flight.
   int            m_rr;
   int            m_tags[$];
   bit            m_err;
   int            m_gnt_cnt[N];
   int            m_stall;
   int            e_win;
   logic [N-1:0]  e_gnt, e_rvalid;
   logic          e_wr_en, e_rd_en;
   logic [AW-1:0] e_wr_addr, e_rd_addr;
   logic [DW-1:0] e_wr_data, e_rdata;

   function automatic logic [DW-1:0] rand_dw();
      logic [DW-1:0] r;
      for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic new_cmd(input int p, input bit we);
      p_we[p]              = we;
      p_addr[p*AW +: AW]   = AW'($urandom);
      p_wdata[p*DW +: DW]  = rand_dw();
   endtask

   task automatic model_reset();
      m_rr  = N - 1;
      m_tags.delete();
      m_err = 1'b0;
      for (int i = 0; i < N; i++) m_gnt_cnt[i] = 0;
      m_stall = 0;
   endtask

   task automatic model_eval();
      e_win = -1;
      e_gnt = '0; e_rvalid = '0; e_wr_en = 1'b0; e_rd_en = 1'b0;
      e_wr_addr = '0; e_rd_addr = '0; e_wr_data = '0; e_rdata = '0;
      for (int k = 1; k <= N; k++) begin
         int i;
         i = (m_rr + k) % N;
         if (e_win < 0 && p_req[i] &&
             (p_we[i] ? !ddr_wr_busy : (!ddr_rd_busy && m_tags.size() < RO)))
            e_win = i;
      end
      if (e_win >= 0) begin
         e_gnt[e_win] = 1'b1;
         if (p_we[e_win]) begin
            e_wr_en   = 1'b1;
            e_wr_addr = p_addr[e_win*AW +: AW];
            e_wr_data = p_wdata[e_win*DW +: DW];
         end else begin
            e_rd_en   = 1'b1;
            e_rd_addr = p_addr[e_win*AW +: AW];
         end
      end
      if (ddr_rd_data_valid && m_tags.size() > 0) begin
         e_rvalid[m_tags[0]] = 1'b1;
         e_rdata = ddr_rd_data;
      end
   endtask

   task automatic model_commit();
      if (ddr_rd_data_valid) begin
         if (m_tags.size() > 0) void'(m_tags.pop_front());
         else m_err = 1'b1;
      end
      if (e_win >= 0) begin
         if (!p_we[e_win]) m_tags.push_back(e_win);
         m_rr = e_win;
         m_gnt_cnt[e_win]++;
      end else if (|p_req) begin
         m_stall++;
      end
   endtask

   task automatic to_check();
      @(negedge clk);
      model_eval();
   endtask

   task automatic to_next();
      @(posedge clk);
      model_commit();
      #1;
   endtask

   task automatic idle_inputs();
      p_req = '0; p_we = '0; p_addr = '0; p_wdata = '0;
      ddr_wr_busy = 1'b0; ddr_rd_busy = 1'b0;
      ddr_rd_data = '0; ddr_rd_data_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      p_req[0] = 1'b1; new_cmd(0, 1'b0);
      repeat (3) begin
         to_check();
         to_next();
         new_cmd(0, 1'b0);
      end
      n_vec++;
      if (rd_outstanding !== CW'(3)) begin
         n_err++; $display("FAIL reset_pre_outst: got %0d want 3", rd_outstanding);
      end
      rst_n = 1'b0;
      idle_inputs();
      @(negedge clk);
      n_vec++;
      if ({p_gnt, p_rvalid, ddr_wr_en, ddr_rd_en, err_orphan_rd} !== '0 ||
          ddr_wr_addr !== '0 || ddr_rd_addr !== '0 || ddr_wr_data !== '0 || p_rdata !== '0) begin
         n_err++; $display("FAIL reset_outputs: gnt=%b rvalid=%b wr_en=%b rd_en=%b err=%b want all 0",
                           p_gnt, p_rvalid, ddr_wr_en, ddr_rd_en, err_orphan_rd);
      end
      n_vec++;
      if (rd_outstanding !== '0) begin
         n_err++; $display("FAIL reset_outst: got %0d want 0", rd_outstanding);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      p_req = '1;
      for (int p = 0; p < N; p++) new_cmd(p, 1'b1);
      to_check();
      n_vec++;
      if (p_gnt !== 3'b001) begin
         n_err++; $display("FAIL reset_first_gnt: got %b want 001", p_gnt);
      end
      to_next();
   endtask

   task automatic test_write_rr();
      logic [N-1:0] want;
      do_reset();
      p_req = '1;
      for (int p = 0; p < N; p++) new_cmd(p, 1'b1);
      for (int k = 0; k < 6; k++) begin
         to_check();
         want = N'(1) << (k % N);
         n_vec++;
         if (p_gnt !== want || ddr_wr_en !== 1'b1) begin
            n_err++; $display("FAIL write_rr_gnt[%0d]: got %b en=%b want %b en=1", k, p_gnt, ddr_wr_en, want);
         end
         n_vec++;
         if (ddr_wr_addr !== p_addr[(k % N)*AW +: AW] || ddr_wr_data !== p_wdata[(k % N)*DW +: DW]) begin
            n_err++; $display("FAIL write_rr_addr[%0d]: got %h want %h", k, ddr_wr_addr, p_addr[(k % N)*AW +: AW]);
         end
         to_next();
         new_cmd(k % N, 1'b1);
      end
   endtask

   task automatic test_rd_busy();
      do_reset();
      p_req = 3'b011;
      new_cmd(0, 1'b0);
      new_cmd(1, 1'b1);
      ddr_rd_busy = 1'b1;
      to_check();
      n_vec++;
      if (p_gnt !== 3'b010 || ddr_wr_en !== 1'b1 || ddr_rd_en !== 1'b0) begin
         n_err++; $display("FAIL rd_busy_gnt: got %b wr=%b rd=%b want 010 wr=1 rd=0", p_gnt, ddr_wr_en, ddr_rd_en);
      end
      to_next();
      p_req[1] = 1'b0;
      ddr_rd_busy = 1'b0;
      to_check();
      n_vec++;
      if (p_gnt !== 3'b001 || ddr_rd_en !== 1'b1 || ddr_rd_addr !== p_addr[0 +: AW]) begin
         n_err++; $display("FAIL rd_release_gnt: got %b rd=%b addr=%h want 001 rd=1 addr=%h",
                           p_gnt, ddr_rd_en, ddr_rd_addr, p_addr[0 +: AW]);
      end
      to_next();
   endtask

   task automatic test_tag_full();
      do_reset();
      p_req[0] = 1'b1; new_cmd(0, 1'b0);
      for (int k = 0; k < RO; k++) begin
         to_check();
         n_vec++;
         if (p_gnt !== 3'b001 || ddr_rd_en !== 1'b1) begin
            n_err++; $display("FAIL fill_gnt[%0d]: got %b rd=%b want 001 rd=1", k, p_gnt, ddr_rd_en);
         end
         to_next();
         new_cmd(0, 1'b0);
      end
      to_check();
      n_vec++;
      if (rd_outstanding !== CW'(RO)) begin
         n_err++; $display("FAIL full_outst: got %0d want %0d", rd_outstanding, RO);
      end
      n_vec++;
      if (p_gnt !== '0 || ddr_rd_en !== 1'b0) begin
         n_err++; $display("FAIL full_blocks_rd: got gnt=%b rd=%b want 000 rd=0", p_gnt, ddr_rd_en);
      end
      to_next();
      p_req[1] = 1'b1; new_cmd(1, 1'b1);
      to_check();
      n_vec++;
      if (p_gnt !== 3'b010 || ddr_wr_en !== 1'b1) begin
         n_err++; $display("FAIL full_wr_ok: got gnt=%b wr=%b want 010 wr=1", p_gnt, ddr_wr_en);
      end
      to_next();
   endtask

   task automatic test_return_order();
      int            order[3] = '{2, 0, 1};
      logic [DW-1:0] d;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         p_req = '0; p_req[order[k]] = 1'b1; new_cmd(order[k], 1'b0);
         to_check();
         to_next();
      end
      p_req = '0;
      for (int k = 0; k < 3; k++) begin
         d = rand_dw();
         ddr_rd_data = d; ddr_rd_data_valid = 1'b1;
         to_check();
         n_vec++;
         if (p_rvalid !== (N'(1) << order[k]) || p_rdata !== d) begin
            n_err++; $display("FAIL return_order[%0d]: got rvalid=%b want %b (data ok=%0d)",
                              k, p_rvalid, N'(1) << order[k], p_rdata === d);
         end
         to_next();
      end
      ddr_rd_data_valid = 1'b0;
      n_vec++;
      if (rd_outstanding !== '0 || err_orphan_rd !== 1'b0) begin
         n_err++; $display("FAIL return_drain: got outst=%0d err=%b want 0 0", rd_outstanding, err_orphan_rd);
      end
   endtask

   task automatic test_orphan();
      do_reset();
      ddr_rd_data = rand_dw(); ddr_rd_data_valid = 1'b1;
      to_check();
      n_vec++;
      if (p_rvalid !== '0 || p_rdata !== '0 || err_orphan_rd !== 1'b0) begin
         n_err++; $display("FAIL orphan_pulse: got rvalid=%b err=%b want 000 0", p_rvalid, err_orphan_rd);
      end
      to_next();
      ddr_rd_data_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         to_check();
         n_vec++;
         if (err_orphan_rd !== 1'b1) begin
            n_err++; $display("FAIL orphan_sticky[%0d]: got %b want 1", k, err_orphan_rd);
         end
         to_next();
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         for (int p = 0; p < N; p++) begin
            if (!p_req[p] || (e_win == p)) begin
               p_req[p] = ($urandom_range(0, 99) < 55);
               new_cmd(p, $urandom_range(0, 1) == 1);
            end else if ($urandom_range(0, 99) < 5) begin
               p_req[p] = 1'b0;
            end
         end
         ddr_wr_busy       = ($urandom_range(0, 99) < 25);
         ddr_rd_busy       = ($urandom_range(0, 99) < 25);
         ddr_rd_data       = rand_dw();
         ddr_rd_data_valid = (m_tags.size() > 0) && ($urandom_range(0, 99) < 40);
         to_check();
         n_vec++;
         if (p_gnt !== e_gnt || ddr_wr_en !== e_wr_en || ddr_rd_en !== e_rd_en) begin
            n_err++; $display("FAIL rand_gnt[%0d]: got %b/%b/%b want %b/%b/%b",
                              c, p_gnt, ddr_wr_en, ddr_rd_en, e_gnt, e_wr_en, e_rd_en);
         end
         n_vec++;
         if (ddr_wr_addr !== e_wr_addr || ddr_rd_addr !== e_rd_addr || ddr_wr_data !== e_wr_data) begin
            n_err++; $display("FAIL rand_addr[%0d]: got wr=%h rd=%h want wr=%h rd=%h",
                              c, ddr_wr_addr, ddr_rd_addr, e_wr_addr, e_rd_addr);
         end
         n_vec++;
         if (p_rvalid !== e_rvalid || p_rdata !== e_rdata) begin
            n_err++; $display("FAIL rand_ret[%0d]: got rvalid=%b want %b", c, p_rvalid, e_rvalid);
         end
         n_vec++;
         if (rd_outstanding !== CW'(m_tags.size()) || err_orphan_rd !== m_err) begin
            n_err++; $display("FAIL rand_state[%0d]: got outst=%0d err=%b want %0d %b",
                              c, rd_outstanding, err_orphan_rd, m_tags.size(), m_err);
         end
         to_next();
      end
`ifdef DDR_ARB_PERF_CNT_EN
      for (int p = 0; p < N; p++) begin
         n_vec++;
         if (perf_gnt_cnt[p*32 +: 32] !== 32'(m_gnt_cnt[p])) begin
            n_err++; $display("FAIL perf_gnt[%0d]: got %0d want %0d", p, perf_gnt_cnt[p*32 +: 32], m_gnt_cnt[p]);
         end
      end
      n_vec++;
      if (perf_stall_cnt !== 32'(m_stall)) begin
         n_err++; $display("FAIL perf_stall: got %0d want %0d", perf_stall_cnt, m_stall);
      end
`endif
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      model_reset();
      e_win = -1;
      test_reset();
      test_write_rr();
      test_rd_busy();
      test_tag_full();
      test_return_order();
      test_orphan();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
